// File: rtl/rv32i_basereg.sv
// RV32I integer register file: 32 x WIDTH registers, two combinational read ports
// with write-through bypass, one synchronous write port, x0 hardwired to zero.
module rv32i_basereg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  input  logic [4:0]       i_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  input  logic             i_we,
  output logic [WIDTH-1:0] o_rs1_data,
  output logic [WIDTH-1:0] o_rs2_data
);

  logic [WIDTH-1:0] regs [0:31];
  logic             wr_valid;

  assign wr_valid = i_we && (i_rd_addr != 5'd0) && !rst;

  // regs[0] is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[i_rd_addr] <= i_rd_data;
    end
  end

  // Reset gating also suppresses the bypass path while rst is held
  always_comb begin
    o_rs1_data = regs[i_rs1_addr];
    if (rst || i_rs1_addr == 5'd0) begin
      o_rs1_data = '0;
    end else if (wr_valid && i_rd_addr == i_rs1_addr) begin
      o_rs1_data = i_rd_data;
    end
  end

  always_comb begin
    o_rs2_data = regs[i_rs2_addr];
    if (rst || i_rs2_addr == 5'd0) begin
      o_rs2_data = '0;
    end else if (wr_valid && i_rd_addr == i_rs2_addr) begin
      o_rs2_data = i_rd_data;
    end
  end

endmodule

// File: tb/tb_rv32i_basereg.sv
// Self-checking bench for rv32i_basereg: directed cases plus random traffic
// checked against an array model of the architectural register file.
module tb_rv32i_basereg;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   rs1, rs2, rd;
  logic [W-1:0] wd;
  logic         we;
  logic [W-1:0] o1, o2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] mdl [32];

  rv32i_basereg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (rs1),
    .i_rs2_addr (rs2),
    .i_rd_addr  (rd),
    .i_rd_data  (wd),
    .i_we       (we),
    .o_rs1_data (o1),
    .o_rs2_data (o2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view: zero under reset or for x0, pending write wins, else stored value
  function automatic logic [W-1:0] ref_read(input logic [4:0] a);
    if (rst) return '0;
    if (a == 5'd0) return '0;
    if (we && rd == a) return wd;
    return mdl[a];
  endfunction

  task automatic check_ports(input string tag);
    chk({tag, "_rs1"}, o1, ref_read(rs1));
    chk({tag, "_rs2"}, o2, ref_read(rs2));
  endtask

  task automatic tick;
    @(posedge clk);
    if (!rst && we && rd != 5'd0) mdl[rd] = wd;
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  initial begin
    logic [W-1:0] vals [32];

    we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
    set_rst(1'b1);
    #1;
    chk("reset_rs1", o1, '0);
    chk("reset_rs2", o2, '0);

    // write attempt and bypass attempt during reset
    we = 1'b1; rd = 5'd4; wd = 32'h5555_AAAA; rs1 = 5'd4; rs2 = 5'd4;
    #1;
    chk("reset_bypass_blocked", o1, '0);
    tick();
    set_rst(1'b0);
    we = 1'b0;
    #1;
    chk("reset_write_blocked", o2, '0);

    // write x1, then read it back
    tick();
    we = 1'b1; rd = 5'd1; wd = 32'hA5A5_A5A5;
    tick();
    we = 1'b0; rs1 = 5'd1; wd = '0;
    #1;
    chk("x1_read", o1, 32'hA5A5_A5A5);
    tick();
    chk("x1_read_after_clk", o1, 32'hA5A5_A5A5);

    // writes to x0 are dropped, no bypass
    we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    chk("x0_no_bypass", o1, '0);
    tick();
    we = 1'b0;
    #1;
    chk("x0_rs1", o1, '0);
    chk("x0_rs2", o2, '0);

    // back-to-back writes x5, x31
    we = 1'b1; rd = 5'd5; wd = 32'h1234_5678;
    tick();
    rd = 5'd31; wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
    #1;
    chk("x5_read", o1, 32'h1234_5678);
    chk("x31_read", o2, 32'hDEAD_BEEF);

    // same-cycle bypass
    we = 1'b1; rd = 5'd7; wd = 32'hCAFE_F00D; rs1 = 5'd7; rs2 = 5'd5;
    #1;
    chk("bypass_x7", o1, 32'hCAFE_F00D);
    chk("bypass_other_port", o2, 32'h1234_5678);
    tick();
    we = 1'b0;
    #1;
    chk("x7_stored", o1, 32'hCAFE_F00D);

    // data changes with write disabled must not disturb x3
    we = 1'b1; rd = 5'd3; wd = 32'h0000_0001;
    tick();
    we = 1'b0; rs2 = 5'd3;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      tick();
      chk("x3_hold", o2, 32'h0000_0001);
    end

    // identical read addresses return identical data
    rs1 = 5'd31; rs2 = 5'd31;
    #1;
    chk("same_addr_rs1", o1, 32'hDEAD_BEEF);
    chk("same_addr_rs2", o2, 32'hDEAD_BEEF);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      check_ports("rand");
      tick();
    end

    // reset asserted mid-way through a write cycle cancels it
    we = 1'b1; rd = 5'd9; wd = 32'h0BAD_F00D; rs1 = 5'd9; rs2 = 5'd31;
    #1;
    set_rst(1'b1);
    #1;
    chk("midwrite_rst_rs1", o1, '0);
    chk("midwrite_rst_rs2", o2, '0);
    tick();
    set_rst(1'b0);
    we = 1'b0;
    #1;
    chk("midwrite_cancel", o1, '0);
    tick();

    // load every register, then pulse reset between edges
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); wd = $urandom | 32'h1; vals[i] = wd;
      tick();
    end
    we = 1'b0; rs1 = 5'd17; rs2 = 5'd30;
    #1;
    chk("loaded_x17", o1, vals[17]);
    chk("loaded_x30", o2, vals[30]);
    set_rst(1'b1);
    #1;
    chk("pulse_rst_rs1", o1, '0);
    chk("pulse_rst_rs2", o2, '0);
    set_rst(1'b0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk("post_rst_rs1", o1, '0);
      chk("post_rst_rs2", o2, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_basereg.md
RV32I_BASEREG -- requirements
Module: rv32i_basereg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which is the data width of each register and of the data ports.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all writes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_rs1_addr, input, 5 bits: read port 1 register index.
REQ-005 The block SHALL have port i_rs2_addr, input, 5 bits: read port 2 register index.
REQ-006 The block SHALL have port i_rd_addr, input, 5 bits: write port register index.
REQ-007 The block SHALL have port i_rd_data, input, WIDTH bits: write data.
REQ-008 The block SHALL have port i_we, input, 1 bit: write enable, active-high.
REQ-009 The block SHALL have port o_rs1_data, output, WIDTH bits: read data for i_rs1_addr.
REQ-010 The block SHALL have port o_rs2_data, output, WIDTH bits: read data for i_rs2_addr.

Function
REQ-011 The block SHALL hold 32 registers x0..x31, each WIDTH bits wide.
REQ-012 x0 SHALL always read as 0; writes to x0 SHALL be ignored with no side effect.
REQ-013 On a rising clk edge with i_we=1, rst=0 and i_rd_addr != 0, register[i_rd_addr] SHALL take i_rd_data.
REQ-014 With i_we=0, no register SHALL change.
REQ-015 Reads SHALL be combinational, with zero-cycle latency from address change to output.
REQ-016 A write SHALL be visible on a read port no later than the first clk edge after the write edge.
REQ-017 Write-through bypass: when i_we=1, i_rd_addr != 0 and i_rd_addr equals a read address in the same cycle, that read port SHALL output i_rd_data; otherwise it SHALL output the stored value.
REQ-018 Both read ports SHALL be fully independent; identical rs1/rs2 addresses SHALL return identical data.
REQ-019 X/Z on i_rd_data SHALL be stored only when i_we=1; no other input combination SHALL corrupt stored state.

Reset
REQ-020 While rst=1, all 32 registers SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-021 While rst=1, both outputs SHALL read 0 and writes SHALL be blocked, including any bypass.
REQ-022 Deasserting rst SHALL leave all registers at 0; the first write takes effect on the next rising edge with i_we=1.
REQ-023 Asserting rst in the middle of a write cycle SHALL cancel that write.

Verification
REQ-024 Reset, then write 0xA5A5A5A5 to x1 with i_we=1 for one edge, then set i_we=0 and rs1=1 -> o_rs1_data = 0xA5A5A5A5 after one clock.
REQ-025 Write 0xFFFFFFFF to x0, then read rs1=0 and rs2=0 -> both outputs = 0.
REQ-026 Write x5=0x12345678 and x31=0xDEADBEEF on consecutive edges, then read rs1=5 and rs2=31 -> 0x12345678 and 0xDEADBEEF.
REQ-027 With i_we=1, rd=7, data=0xCAFEF00D, and rs1=7 in the same cycle -> o_rs1_data = 0xCAFEF00D before the edge (bypass).
REQ-028 Write x3=0x1, set i_we=0 with i_rd_data changing, read rs2=3 -> 0x00000001 unchanged.
REQ-029 Load x1..x31, then pulse rst mid-cycle with no clock edge -> all reads = 0 immediately and remain 0 after rst falls.
